// File: rtl/note_slot_scheduler_if.sv
// note_slot_scheduler_if: control inputs and slot/event outputs of the note slot scheduler
interface note_slot_scheduler_if #(parameter int NSLOT = 4);
  logic               restart;
  logic               stop_or_endgame;
  logic [6:0]         beat_cnt;
  logic [3:0]         chart_lanes;
  logic [3:0]         hit_lane;
  logic [NSLOT-1:0]   slot_valid;
  logic [2*NSLOT-1:0] slot_lane;
  logic [10*NSLOT-1:0] slot_h;
  logic [3:0]         hit_ok;
  logic [3:0]         hit_bad;
  logic               miss;
  logic               spawn_drop;
  logic [7:0]         hit_cnt;
  logic [7:0]         miss_cnt;
  modport master (
    output restart, stop_or_endgame, beat_cnt, chart_lanes, hit_lane,
    input  slot_valid, slot_lane, slot_h, hit_ok, hit_bad, miss, spawn_drop, hit_cnt, miss_cnt
  );
  modport slave (
    input  restart, stop_or_endgame, beat_cnt, chart_lanes, hit_lane,
    output slot_valid, slot_lane, slot_h, hit_ok, hit_bad, miss, spawn_drop, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/note_slot_scheduler.sv
// note_slot_scheduler: shared falling-note slot pool with spawn, motion, hit and miss handling
module note_slot_scheduler #(
  parameter int NSLOT   = 4,
  parameter int H_SPAWN = 120,
  parameter int H_MAX   = 720,
  parameter int HIT_LO  = 600,
  parameter int HIT_HI  = 680
) (
  input logic                  clk,
  input logic                  rst,
  note_slot_scheduler_if.slave bus
);
  logic [NSLOT-1:0] r_valid;
  logic [1:0]       r_lane [NSLOT];
  logic [9:0]       r_h [NSLOT];
  logic [6:0]       r_pre_beat;
  logic [3:0]       r_hit_ok, r_hit_bad;
  logic             r_miss, r_drop;
  logic [7:0]       r_hit_cnt, r_miss_cnt;
  logic             w_run, w_new_beat;
  logic [NSLOT-1:0] w_win, w_hit_free, w_miss_free, w_spawn;
  logic [1:0]       w_spawn_lane [NSLOT];
  logic [3:0]       w_hit_ok, w_hit_bad, w_drops, w_nmiss;
  logic [8:0]       w_hit_sum;
  logic [9:0]       w_miss_sum;
  assign w_run      = !bus.stop_or_endgame;
  assign w_new_beat = bus.beat_cnt > r_pre_beat;
  // per lane: pick the in-window slot closest to the bottom, lowest index on ties
  always_comb begin
    logic             found;
    logic [9:0]       best_h;
    logic [NSLOT-1:0] best;
    w_win = '0;
    w_hit_free = '0;
    w_hit_ok = '0;
    w_hit_bad = '0;
    found = 1'b0;
    best_h = '0;
    best = '0;
    for (int k = 0; k < NSLOT; k++)
      w_win[k] = r_valid[k] && r_h[k] >= 10'(HIT_LO) && r_h[k] <= 10'(HIT_HI);
    for (int l = 0; l < 4; l++) begin
      found = 1'b0;
      best_h = '0;
      best = '0;
      for (int k = 0; k < NSLOT; k++)
        if (w_win[k] && r_lane[k] == 2'(l) && (!found || r_h[k] > best_h)) begin
          found = 1'b1;
          best_h = r_h[k];
          best = NSLOT'(1) << k;
        end
      if (w_run && bus.hit_lane[l]) begin
        w_hit_free = w_hit_free | best;
        w_hit_ok[l] = found;
        w_hit_bad[l] = !found;
      end
    end
  end
  always_comb begin
    w_miss_free = '0;
    for (int k = 0; k < NSLOT; k++)
      w_miss_free[k] = w_run && r_valid[k] && r_h[k] == 10'(H_MAX) && !w_hit_free[k];
  end
  // spawns only see slots free at cycle start; slots freed this cycle wait one cycle
  always_comb begin
    logic placed;
    placed = 1'b0;
    w_spawn = '0;
    w_drops = '0;
    for (int k = 0; k < NSLOT; k++) w_spawn_lane[k] = 2'd0;
    for (int l = 0; l < 4; l++)
      if (w_run && w_new_beat && bus.chart_lanes[l]) begin
        placed = 1'b0;
        for (int k = 0; k < NSLOT; k++)
          if (!placed && !r_valid[k] && !w_spawn[k]) begin
            w_spawn[k] = 1'b1;
            w_spawn_lane[k] = 2'(l);
            placed = 1'b1;
          end
        if (!placed) w_drops = w_drops + 4'd1;
      end
  end
  assign w_nmiss    = 4'($countones(w_miss_free));
  assign w_hit_sum  = {1'b0, r_hit_cnt} + 9'($countones(w_hit_ok));
  assign w_miss_sum = {2'b0, r_miss_cnt} + 10'(w_nmiss) + 10'(w_drops);
  always_ff @(posedge clk) begin
    if (rst || bus.restart) begin
      r_valid <= '0;
      for (int k = 0; k < NSLOT; k++) begin
        r_lane[k] <= 2'd0;
        r_h[k] <= 10'(H_MAX);
      end
      r_pre_beat <= '0;
      r_hit_ok <= '0;
      r_hit_bad <= '0;
      r_miss <= 1'b0;
      r_drop <= 1'b0;
      r_hit_cnt <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_pre_beat <= bus.beat_cnt;
      r_hit_ok <= w_hit_ok;
      r_hit_bad <= w_hit_bad;
      r_miss <= |w_miss_free;
      r_drop <= |w_drops;
      r_hit_cnt <= w_hit_sum > 9'd255 ? 8'd255 : w_hit_sum[7:0];
      r_miss_cnt <= w_miss_sum > 10'd255 ? 8'd255 : w_miss_sum[7:0];
      for (int k = 0; k < NSLOT; k++)
        if (w_hit_free[k] || w_miss_free[k]) begin
          r_valid[k] <= 1'b0;
          r_h[k] <= 10'(H_MAX);
        end else if (w_spawn[k]) begin
          r_valid[k] <= 1'b1;
          r_lane[k] <= w_spawn_lane[k];
          r_h[k] <= 10'(H_SPAWN);
        end else if (w_run && r_valid[k] && r_h[k] < 10'(H_MAX)) begin
          r_h[k] <= r_h[k] + 10'd1;
        end
    end
  end
  always_comb begin
    bus.slot_lane = '0;
    bus.slot_h = '0;
    for (int k = 0; k < NSLOT; k++) begin
      bus.slot_lane[2*k +: 2] = r_lane[k];
      bus.slot_h[10*k +: 10] = r_h[k];
    end
  end
  assign bus.slot_valid = r_valid;
  assign bus.hit_ok     = r_hit_ok;
  assign bus.hit_bad    = r_hit_bad;
  assign bus.miss       = r_miss;
  assign bus.spawn_drop = r_drop;
  assign bus.hit_cnt    = r_hit_cnt;
  assign bus.miss_cnt   = r_miss_cnt;
endmodule

// File: tb/tb_note_slot_scheduler.sv
// tb_note_slot_scheduler: vector table with scoreboard plus hand sequences for same-lane, freeze, restart, saturation
module tb_note_slot_scheduler;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  note_slot_scheduler_if #(.NSLOT(4)) bus ();
  note_slot_scheduler #(.NSLOT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    int n;
    logic rs;
    logic [6:0] beat;
    logic [3:0] chart, hit, v;
    logic [39:0] h;
    logic [7:0] ln;
    logic [3:0] hok, hbad;
    logic ms, dr;
    logic [7:0] hc, mc;
  } vec_t;
  vec_t tbl[14];
  vec_t q[$];
  vec_t e;
  logic [6:0] acc;
  function automatic logic [39:0] packh(input int a, b, c, d);
    return {10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction
  function automatic vec_t mk(input int n, rs, beat, chart, hit, v, input logic [39:0] h,
                              input int ln, hok, hbad, ms, dr, hc, mc);
    vec_t r;
    r.n = n; r.rs = 1'(rs); r.beat = 7'(beat); r.chart = 4'(chart); r.hit = 4'(hit);
    r.v = 4'(v); r.h = h; r.ln = 8'(ln); r.hok = 4'(hok); r.hbad = 4'(hbad);
    r.ms = 1'(ms); r.dr = 1'(dr); r.hc = 8'(hc); r.mc = 8'(mc);
    return r;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic drv(input logic rs, input logic st, input logic [6:0] b, input logic [3:0] c, input logic [3:0] h);
    bus.restart = rs; bus.stop_or_endgame = st; bus.beat_cnt = b; bus.chart_lanes = c; bus.hit_lane = h;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [9:0] hs(input int k);
    return bus.slot_h[10*k +: 10];
  endfunction
  initial begin
    logic [39:0] h720;
    h720 = packh(720, 720, 720, 720);
    tbl[0]  = mk(1,   1, 3, 0,  0, 0,  h720,                        0,    0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1,   0, 3, 0,  0, 0,  h720,                        0,    0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1,   0, 4, 1,  0, 1,  packh(120, 720, 720, 720),   0,    0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(600, 0, 4, 0,  0, 1,  h720,                        0,    0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1,   0, 4, 0,  0, 0,  h720,                        0,    0, 0, 1, 0, 0, 1);
    tbl[5]  = mk(1,   0, 4, 0,  0, 0,  h720,                        0,    0, 0, 0, 0, 0, 1);
    tbl[6]  = mk(1,   0, 5, 15, 0, 15, packh(120, 120, 120, 120),   'he4, 0, 0, 0, 0, 0, 1);
    tbl[7]  = mk(1,   0, 6, 3,  0, 15, packh(121, 121, 121, 121),   'he4, 0, 0, 0, 1, 0, 3);
    tbl[8]  = mk(478, 0, 6, 0,  0, 15, packh(599, 599, 599, 599),   'he4, 0, 0, 0, 0, 0, 3);
    tbl[9]  = mk(1,   0, 6, 0,  4, 15, packh(600, 600, 600, 600),   'he4, 0, 4, 0, 0, 0, 3);
    tbl[10] = mk(1,   0, 6, 0,  4, 11, packh(601, 601, 720, 601),   'he4, 4, 0, 0, 0, 1, 3);
    tbl[11] = mk(119, 0, 6, 0,  0, 11, h720,                        'he4, 0, 0, 0, 0, 1, 3);
    tbl[12] = mk(1,   0, 6, 0,  0, 0,  h720,                        'he4, 0, 0, 1, 0, 1, 6);
    tbl[13] = mk(1,   0, 6, 0,  1, 0,  h720,                        'he4, 0, 1, 0, 0, 1, 6);
    rst = 1'b1;
    drv(0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("rst.valid", 64'(bus.slot_valid), 64'(0));
    chk("rst.h", 64'(bus.slot_h), 64'(h720));
    chk("rst.cnt", 64'({bus.hit_cnt, bus.miss_cnt}), 64'(0));
    chk("rst.pulse", 64'({bus.hit_ok, bus.hit_bad, bus.miss, bus.spawn_drop}), 64'(0));
    rst = 1'b0;
    foreach (tbl[i]) begin
      drv(tbl[i].rs, 0, tbl[i].beat, tbl[i].chart, tbl[i].hit);
      q.push_back(tbl[i]);
      tick();
      drv(0, 0, tbl[i].beat, 0, 0);
      repeat (tbl[i].n - 1) tick();
      e = q.pop_front();
      chk($sformatf("v%0d.valid", i), 64'(bus.slot_valid), 64'(e.v));
      chk($sformatf("v%0d.h", i), 64'(bus.slot_h), 64'(e.h));
      chk($sformatf("v%0d.lane", i), 64'(bus.slot_lane), 64'(e.ln));
      chk($sformatf("v%0d.hit_ok", i), 64'(bus.hit_ok), 64'(e.hok));
      chk($sformatf("v%0d.hit_bad", i), 64'(bus.hit_bad), 64'(e.hbad));
      chk($sformatf("v%0d.miss", i), 64'(bus.miss), 64'(e.ms));
      chk($sformatf("v%0d.drop", i), 64'(bus.spawn_drop), 64'(e.dr));
      chk($sformatf("v%0d.hit_cnt", i), 64'(bus.hit_cnt), 64'(e.hc));
      chk($sformatf("v%0d.miss_cnt", i), 64'(bus.miss_cnt), 64'(e.mc));
    end
    rst = 1'b1;
    drv(0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    drv(0, 0, 1, 4'b0010, 0);
    tick();
    chk("same.spawn0", 64'({bus.slot_valid, bus.slot_lane[1:0], hs(0)}), 64'({4'b0001, 2'd1, 10'd120}));
    drv(0, 0, 1, 0, 0);
    repeat (39) tick();
    drv(0, 0, 2, 4'b0010, 0);
    tick();
    chk("same.spawn1", 64'({bus.slot_valid, bus.slot_lane[3:0], hs(0), hs(1)}), 64'({4'b0011, 4'b0101, 10'd160, 10'd120}));
    drv(0, 0, 2, 0, 0);
    repeat (490) tick();
    chk("same.pre", 64'({hs(0), hs(1)}), 64'({10'd650, 10'd610}));
    drv(0, 0, 2, 0, 4'b0010);
    tick();
    chk("same.hit", 64'({bus.slot_valid, bus.hit_ok, bus.hit_bad, hs(0), hs(1)}), 64'({4'b0010, 4'b0010, 4'b0, 10'd720, 10'd611}));
    chk("same.hit_cnt", 64'(bus.hit_cnt), 64'(1));
    drv(0, 0, 2, 0, 0);
    tick();
    chk("same.after", 64'({bus.hit_ok, hs(1)}), 64'({4'b0, 10'd612}));
    acc = '0;
    for (int c = 0; c < 50; c++) begin
      drv(0, 1, c < 25 ? 7'd2 : 7'd3, c == 25 ? 4'b0001 : 4'b0, c % 7 == 0 ? 4'b0010 : 4'b0);
      tick();
      acc |= {bus.hit_ok, bus.hit_bad[0], bus.miss, bus.spawn_drop};
    end
    chk("frz.pulses", 64'(acc), 64'(0));
    chk("frz.state", 64'({bus.slot_valid, hs(1), bus.hit_cnt, bus.miss_cnt}), 64'({4'b0010, 10'd612, 8'd1, 8'd0}));
    drv(0, 0, 3, 0, 0);
    tick();
    chk("frz.resume", 64'({bus.slot_valid, hs(1), bus.spawn_drop}), 64'({4'b0010, 10'd613, 1'b0}));
    drv(0, 0, 4, 4'b0101, 0);
    tick();
    chk("rs.fill", 64'({bus.slot_valid, hs(0), hs(1), hs(2), bus.slot_lane[5:0]}), 64'({4'b0111, 10'd120, 10'd614, 10'd120, 6'b100100}));
    drv(0, 0, 4, 0, 4'b0010);
    tick();
    chk("rs.hit", 64'({bus.slot_valid, bus.hit_ok, bus.hit_cnt}), 64'({4'b0101, 4'b0010, 8'd2}));
    drv(1, 0, 5, 4'b1111, 4'b0001);
    tick();
    chk("rs.valid", 64'(bus.slot_valid), 64'(0));
    chk("rs.h", 64'(bus.slot_h), 64'(h720));
    chk("rs.lane", 64'(bus.slot_lane), 64'(0));
    chk("rs.cnt", 64'({bus.hit_cnt, bus.miss_cnt}), 64'(0));
    chk("rs.pulse", 64'({bus.hit_ok, bus.hit_bad, bus.miss, bus.spawn_drop}), 64'(0));
    drv(0, 0, 5, 0, 0);
    tick();
    chk("rs.next", 64'({bus.slot_valid, bus.hit_ok, bus.hit_bad, bus.miss, bus.spawn_drop, bus.hit_cnt}), 64'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drv(0, 0, 1, 4'b1111, 0);
    tick();
    chk("sat.fill", 64'(bus.slot_valid), 64'(4'b1111));
    for (int b = 2; b <= 65; b++) begin
      drv(0, 0, 7'(b), 4'b1111, 0);
      tick();
      if (b == 3) chk("sat.early", 64'({bus.spawn_drop, bus.miss_cnt}), 64'({1'b1, 8'd8}));
    end
    chk("sat.cnt", 64'({bus.spawn_drop, bus.miss_cnt}), 64'({1'b1, 8'd255}));
    drv(0, 0, 0, 4'b1111, 0);
    tick();
    chk("wrap", 64'({bus.spawn_drop, bus.miss_cnt}), 64'({1'b0, 8'd255}));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
